// File: rtl/main_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : main_ram_arbiter
// Description : Single-port SDRAM arbiter for loader, BSRAM and ROM clients.
//               Define MAIN_RAM_ARB_RR_EN for round-robin BSRAM/ROM arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module main_ram_arbiter #(
  parameter int                 ADDR_W       = 25,
  parameter logic [ADDR_W-21:0] BSRAM_PREFIX = 5'b10000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_done,
  // loader
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic              load_ack,
  // BSRAM
  input  logic              bsram_req,
  input  logic              bsram_we,
  input  logic [19:0]       bsram_addr,
  input  logic [7:0]        bsram_d,
  output logic [7:0]        bsram_q,
  output logic              bsram_ack,
  // ROM
  input  logic              rom_req,
  input  logic              rom_word,
  input  logic [23:0]       rom_addr,
  output logic [15:0]       rom_q,
  output logic              rom_ack,
  // SDRAM controller
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_word,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_LOAD, GNT_BSRAM, GNT_ROM} gnt_t;

  // Last WAIT cycle index at which a controller that never raised busy is given up on.
  localparam logic [1:0] c_guard_last = 2'd2;

  state_t     r_state;
  state_t     w_state_nxt;
  gnt_t       r_gnt;
  gnt_t       w_gnt_sel;
  logic       r_we;
  logic [1:0] r_wait_cnt;
  logic       r_busy_seen;
  logic       w_capture;

`ifdef MAIN_RAM_ARB_RR_EN
  logic r_rr_ptr;  // 0: BSRAM wins the next tie, 1: ROM wins

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
    end else if (r_state == ST_DONE) begin
      if (r_gnt == GNT_BSRAM)    r_rr_ptr <= 1'b1;
      else if (r_gnt == GNT_ROM) r_rr_ptr <= 1'b0;
    end
  end
`endif

  // Eligibility is decided only by load_done; it is sampled in IDLE alone.
  always_comb begin
    w_gnt_sel = GNT_NONE;
    if (!load_done) begin
      if (load_req) w_gnt_sel = GNT_LOAD;
    end else begin
`ifdef MAIN_RAM_ARB_RR_EN
      if (bsram_req && rom_req) w_gnt_sel = r_rr_ptr ? GNT_ROM : GNT_BSRAM;
      else if (bsram_req)       w_gnt_sel = GNT_BSRAM;
      else if (rom_req)         w_gnt_sel = GNT_ROM;
`else
      if (bsram_req)    w_gnt_sel = GNT_BSRAM;
      else if (rom_req) w_gnt_sel = GNT_ROM;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    load_ack    = 1'b0;
    bsram_ack   = 1'b0;
    rom_ack     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_sel != GNT_NONE) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_wr      = r_we;
        mem_rd      = ~r_we;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_busy && (r_busy_seen || r_wait_cnt == c_guard_last)) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        load_ack    = (r_gnt == GNT_LOAD);
        bsram_ack   = (r_gnt == GNT_BSRAM);
        rom_ack     = (r_gnt == GNT_ROM);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt       <= GNT_NONE;
      r_we        <= 1'b0;
      r_wait_cnt  <= '0;
      r_busy_seen <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_word    <= 1'b0;
      rom_q       <= '0;
      bsram_q     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_gnt       <= w_gnt_sel;
          r_wait_cnt  <= '0;
          r_busy_seen <= 1'b0;
          case (w_gnt_sel)
            GNT_LOAD: begin
              r_we     <= 1'b1;
              mem_addr <= load_addr;
              mem_din  <= load_data;
              mem_word <= 1'b1;
            end
            GNT_BSRAM: begin
              r_we     <= bsram_we;
              mem_addr <= {BSRAM_PREFIX, bsram_addr};
              mem_din  <= {bsram_d, bsram_d};
              mem_word <= 1'b0;
            end
            GNT_ROM: begin
              r_we     <= 1'b0;
              mem_addr <= {{(ADDR_W-24){1'b0}}, rom_addr};
              mem_word <= rom_word;
            end
            default: ;
          endcase
        end
        ST_ISSUE: r_busy_seen <= mem_busy;
        ST_WAIT: begin
          r_busy_seen <= r_busy_seen | mem_busy;
          if (r_wait_cnt != c_guard_last) r_wait_cnt <= r_wait_cnt + 2'd1;
        end
        default: ;
      endcase
      // Read data is taken as the access completes so it is valid alongside ack.
      if (w_capture) begin
        if (r_gnt == GNT_ROM)                rom_q   <= mem_dout;
        if (r_gnt == GNT_BSRAM && !r_we)     bsram_q <= mem_dout[7:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_ram_arbiter
// Description : Self-checking bench for main_ram_arbiter (vectors + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_ram_arbiter;

  localparam int WHO_LOAD  = 0;
  localparam int WHO_BSRAM = 1;
  localparam int WHO_ROM   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_done;
  logic        load_req;
  logic [24:0] load_addr;
  logic [15:0] load_data;
  logic        load_ack;
  logic        bsram_req, bsram_we;
  logic [19:0] bsram_addr;
  logic [7:0]  bsram_d, bsram_q;
  logic        bsram_ack;
  logic        rom_req, rom_word;
  logic [23:0] rom_addr;
  logic [15:0] rom_q;
  logic        rom_ack;
  logic [24:0] mem_addr;
  logic        mem_rd, mem_wr, mem_word;
  logic [15:0] mem_din, mem_dout;
  logic        mem_busy;

  always #5 clk = ~clk;

  main_ram_arbiter dut (
    .clk(clk), .reset(reset), .load_done(load_done),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .bsram_req(bsram_req), .bsram_we(bsram_we), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
    .bsram_q(bsram_q), .bsram_ack(bsram_ack),
    .rom_req(rom_req), .rom_word(rom_word), .rom_addr(rom_addr), .rom_q(rom_q), .rom_ack(rom_ack),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_word(mem_word),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  typedef struct {
    logic        ld;
    int          who;
    logic        we;
    logic [24:0] addr;
    logic [15:0] data;
    logic        word;
    int          busy;      // busy cycles after ISSUE; 0 = controller never raises busy
    logic [15:0] dout;
    int          drop_at;   // cycle at which req is withdrawn early (0 = never)
    int          flip_at;   // cycle at which load_done toggles (0 = never)
    logic [24:0] e_addr;
    logic        e_wr;
    logic        e_word;
    logic [15:0] e_din;
    logic [15:0] e_q;
    int          e_ack;     // cycle of ack, counting the request cycle as 0
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] m_rom_q;
  logic [7:0]  m_bsram_q;
  vec_t        tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    load_req  = 1'b0;
    bsram_req = 1'b0;
    rom_req   = 1'b0;
  endtask

  // Reference: address map and data layout from the grant rules; latency from busy profile.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    case (v.who)
      WHO_LOAD: begin
        r.e_addr = v.addr; r.e_wr = 1'b1; r.e_word = 1'b1; r.e_din = v.data; r.e_q = 16'h0;
      end
      WHO_BSRAM: begin
        r.e_addr = 25'h1000000 + 25'(v.addr[19:0]);
        r.e_wr   = v.we; r.e_word = 1'b0;
        r.e_din  = 16'(v.data[7:0]) * 16'h0101;
        r.e_q    = 16'(v.dout[7:0]);
      end
      default: begin
        r.e_addr = 25'(v.addr[23:0]); r.e_wr = 1'b0; r.e_word = v.word;
        r.e_din  = 16'h0; r.e_q = v.dout;
      end
    endcase
    r.e_ack = 1 + ((v.busy == 0) ? 4 : v.busy + 2);
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int          cyc = 0, issue_c = -1, ack_c = -1, n_iss = 0, n_ack = 0, hold_bad = 0;
    logic [2:0]  acks, ack_which = 3'b0;
    logic        got_rd = 1'b0, got_wr = 1'b0, got_word = 1'b0;
    logic [24:0] got_addr = '0;
    logic [15:0] got_din = '0, cap_rom_q = '0;
    logic [7:0]  cap_bsram_q = '0;
    @(negedge clk);
    load_done = v.ld; mem_dout = v.dout; mem_busy = 1'b0;
    case (v.who)
      WHO_LOAD:  begin load_req = 1'b1; load_addr = v.addr; load_data = v.data; end
      WHO_BSRAM: begin bsram_req = 1'b1; bsram_we = v.we; bsram_addr = v.addr[19:0]; bsram_d = v.data[7:0]; end
      default:   begin rom_req = 1'b1; rom_word = v.word; rom_addr = v.addr[23:0]; end
    endcase
    while (cyc < 30 && !(ack_c >= 0 && cyc > ack_c)) begin
      @(negedge clk);
      cyc++;
      if (cyc == v.drop_at) drop_reqs();
      if (cyc == v.flip_at) load_done = ~load_done;
      if (mem_rd || mem_wr) begin
        n_iss++;
        if (issue_c < 0) begin
          issue_c = cyc; got_rd = mem_rd; got_wr = mem_wr; got_word = mem_word;
          got_addr = mem_addr; got_din = mem_din;
        end
      end else if (issue_c >= 0 && ack_c < 0 &&
                   (mem_addr !== got_addr || mem_word !== got_word || (got_wr && mem_din !== got_din)))
        hold_bad++;
      acks = {rom_ack, bsram_ack, load_ack};
      if (acks != 3'b0) begin
        n_ack++;
        if (ack_c < 0) begin
          ack_c = cyc; ack_which = acks; cap_rom_q = rom_q; cap_bsram_q = bsram_q;
        end
        drop_reqs();
      end
      mem_busy = (issue_c >= 0 && cyc > issue_c && cyc <= issue_c + v.busy);
    end
    drop_reqs();
    mem_busy = 1'b0;
    if (v.who == WHO_ROM) m_rom_q = v.e_q;
    if (v.who == WHO_BSRAM && !v.e_wr) m_bsram_q = v.e_q[7:0];
    check({tag, ".issue_cyc"}, issue_c, 1);
    check({tag, ".ack_cyc"}, ack_c, v.e_ack);
    check({tag, ".n_issue"}, n_iss, 1);
    check({tag, ".n_ack"}, n_ack, 1);
    check({tag, ".ack_who"}, ack_which, 32'(1 << v.who));
    check({tag, ".addr"}, got_addr, v.e_addr);
    check({tag, ".wr"}, got_wr, v.e_wr);
    check({tag, ".rd"}, got_rd, !v.e_wr);
    check({tag, ".word"}, got_word, v.e_word);
    if (v.e_wr) check({tag, ".din"}, got_din, v.e_din);
    check({tag, ".hold"}, hold_bad, 0);
    check({tag, ".rom_q"}, cap_rom_q, m_rom_q);
    check({tag, ".bsram_q"}, cap_bsram_q, m_bsram_q);
  endtask

  // BSRAM and ROM both request continuously; record which client each of 4 grants served.
  task automatic arb_seq();
    int cyc = 0, ng = 0, issue_c = -100, last_ack = -100, gap_bad = 0;
    int seq[4];
    int exp_who;
    @(negedge clk);
    load_done = 1'b1; mem_busy = 1'b0; mem_dout = 16'h6C93;
    bsram_req = 1'b1; bsram_we = 1'b0; bsram_addr = 20'h00ABC;
    rom_req = 1'b1; rom_word = 1'b1; rom_addr = 24'h000ABC;
    while (ng < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_rd || mem_wr) begin
        issue_c = cyc;
        if (cyc - last_ack < 2) gap_bad++;
      end
      if (bsram_ack || rom_ack) begin
        seq[ng] = bsram_ack ? WHO_BSRAM : WHO_ROM;
        ng++;
        last_ack = cyc;
      end
      mem_busy = (cyc == issue_c + 1);
    end
    drop_reqs();
    mem_busy = 1'b0;
    check("arb.n_grants", ng, 4);
    check("arb.gap", gap_bad, 0);
    for (int i = 0; i < 4; i++) begin
`ifdef MAIN_RAM_ARB_RR_EN
      exp_who = (i % 2 == 0) ? WHO_BSRAM : WHO_ROM;
`else
      exp_who = WHO_BSRAM;
`endif
      check($sformatf("arb.grant%0d", i), seq[i], exp_who);
    end
  endtask

  task automatic reset_mid_wait();
    int cyc = 0, issue_c = -1, bad = 0;
    @(negedge clk);
    load_done = 1'b1; mem_busy = 1'b0; mem_dout = 16'hDEAD;
    rom_req = 1'b1; rom_word = 1'b1; rom_addr = 24'h00C0DE;
    while (issue_c < 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (mem_rd) issue_c = cyc;
    end
    check("rst_mid.issue_seen", issue_c >= 0, 1);
    @(negedge clk);
    mem_busy = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid.rd_wr", {mem_rd, mem_wr}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({mem_rd, mem_wr, load_ack, bsram_ack, rom_ack} != 5'b0) bad++;
    end
    rom_req = 1'b0; mem_busy = 1'b0; reset = 1'b0;
    m_rom_q = 16'h0; m_bsram_q = 8'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({mem_rd, mem_wr, load_ack, bsram_ack, rom_ack} != 5'b0) bad++;
    end
    check("rst_mid.no_ack", bad, 0);
    check("rst_mid.rom_q", rom_q, 0);
    check("rst_mid.addr", mem_addr, 0);
  endtask

  initial begin
    int   bad;
    vec_t v;
    //         ld  who        we  addr           data      wd busy dout     drp flp e_addr         wr  wd  e_din     e_q       ack
    tbl[0] = '{1'b0, WHO_LOAD, 1'b1, 25'h0000123, 16'hBEEF, 1'b1, 4, 16'h0000, 0, 0, 25'h0000123, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 7};
    tbl[1] = '{1'b1, WHO_ROM, 1'b0, 25'h000FFFE, 16'h0000, 1'b1, 2, 16'h1234, 0, 0, 25'h000FFFE, 1'b0, 1'b1, 16'h0000, 16'h1234, 5};
    tbl[2] = '{1'b1, WHO_BSRAM, 1'b1, 25'h0000010, 16'h005A, 1'b0, 3, 16'h0000, 0, 0, 25'h1000010, 1'b1, 1'b0, 16'h5A5A, 16'h0000, 6};
    tbl[3] = '{1'b1, WHO_BSRAM, 1'b0, 25'h00FFFFF, 16'h0000, 1'b0, 1, 16'hA5C3, 0, 0, 25'h10FFFFF, 1'b0, 1'b0, 16'h0000, 16'h00C3, 4};
    tbl[4] = '{1'b1, WHO_ROM, 1'b0, 25'h0FFFFFF, 16'h0000, 1'b0, 0, 16'h8001, 0, 0, 25'h0FFFFFF, 1'b0, 1'b0, 16'h0000, 16'h8001, 5};
    tbl[5] = '{1'b0, WHO_LOAD, 1'b1, 25'h1FFFFFF, 16'h0000, 1'b1, 0, 16'h0000, 0, 0, 25'h1FFFFFF, 1'b1, 1'b1, 16'h0000, 16'h0000, 5};
    tbl[6] = '{1'b1, WHO_BSRAM, 1'b0, 25'h0012345, 16'h0000, 1'b0, 2, 16'h7E81, 2, 0, 25'h1012345, 1'b0, 1'b0, 16'h0000, 16'h0081, 5};
    tbl[7] = '{1'b0, WHO_LOAD, 1'b1, 25'h0ABCDEF, 16'h1357, 1'b1, 3, 16'h0000, 0, 2, 25'h0ABCDEF, 1'b1, 1'b1, 16'h1357, 16'h0000, 6};
    tbl[8] = '{1'b1, WHO_ROM, 1'b0, 25'h1800000, 16'h0000, 1'b1, 5, 16'hFFFF, 0, 0, 25'h0800000, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 8};

    reset = 1'b1; load_done = 1'b0; mem_busy = 1'b0; mem_dout = 16'h0;
    load_req = 1'b1; load_addr = 25'h1555555; load_data = 16'hFFFF;
    bsram_req = 1'b0; bsram_we = 1'b0; bsram_addr = '0; bsram_d = '0;
    rom_req = 1'b0; rom_word = 1'b0; rom_addr = '0;
    m_rom_q = 16'h0; m_bsram_q = 8'h0;

    // Reset state, with a pending loader request that must not be served.
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if ({mem_rd, mem_wr, mem_word, load_ack, bsram_ack, rom_ack} != 6'b0) bad++;
    end
    check("rst.ctrl", bad, 0);
    check("rst.addr", mem_addr, 0);
    check("rst.din", mem_din, 0);
    check("rst.rom_q", rom_q, 0);
    check("rst.bsram_q", bsram_q, 0);
    load_req = 1'b0;
    reset = 1'b0;

    // Ineligible requesters are ignored in each load_done phase.
    @(negedge clk);
    load_done = 1'b1; load_req = 1'b1; bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_rd || mem_wr || load_ack) bad++;
    end
    check("elig.loader_blocked", bad, 0);
    load_req = 1'b0; load_done = 1'b0; bsram_req = 1'b1; rom_req = 1'b1; bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_rd || mem_wr || bsram_ack || rom_ack) bad++;
    end
    check("elig.clients_blocked", bad, 0);
    drop_reqs();

    arb_seq();
    reset_mid_wait();

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.ld      = 1'($urandom_range(0, 1));
      v.who     = v.ld ? int'($urandom_range(1, 2)) : WHO_LOAD;
      v.we      = 1'($urandom_range(0, 1));
      v.addr    = 25'($urandom);
      v.data    = 16'($urandom);
      v.word    = 1'($urandom_range(0, 1));
      v.busy    = int'($urandom_range(0, 5));
      v.dout    = 16'($urandom);
      v.drop_at = 0;
      v.flip_at = 0;
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
